// File: rtl/pixel_wb_pkg.sv
// -----------------------------------------------------------------------------
// pixel_wb_pkg
// Shared constants for the pixel write buffer:
//   screen geometry, framebuffer address/colour widths, the address of the
//   last framebuffer pixel, the FSM state encoding and the (x, y) -> linear
//   address helper.
// -----------------------------------------------------------------------------
package pixel_wb_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int FB_ADDR_W = 15;
    localparam int COL_W     = 3;

    localparam logic [FB_ADDR_W-1:0] FB_LAST_ADDR = FB_ADDR_W'(SCREEN_W * SCREEN_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    // y*160 + x as (y<<7) + (y<<5) + x, truncated to the framebuffer width.
    function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [7:0] px,
                                                      input logic [6:0] py);
        logic [FB_ADDR_W-1:0] yy;
        logic [FB_ADDR_W-1:0] xx;
        yy = {{(FB_ADDR_W-7){1'b0}}, py};
        xx = {{(FB_ADDR_W-8){1'b0}}, px};
        return (yy << 7) + (yy << 5) + xx;
    endfunction

endpackage

// File: rtl/pixel_wb_fifo.sv
// -----------------------------------------------------------------------------
// pixel_wb_fifo
// Small synchronous FIFO holding {address, colour} plot entries.
// Ports:
//   clk, reset      clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data write an entry (ignored when full)
//   pop             discard the head entry (ignored when empty)
//   full, empty     occupancy flags
//   head            head entry, combinational from registered storage
// -----------------------------------------------------------------------------
module pixel_wb_fifo
    import pixel_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FB_ADDR_W + COL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        head     = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pixel_write_buffer.sv
// -----------------------------------------------------------------------------
// pixel_write_buffer
// Buffers plot requests from the drawing source, converts (x, y) to a linear
// framebuffer address and writes pixels whenever the framebuffer port is
// granted. Also performs a full-screen clear fill on request.
//
// Build option: PIXEL_WB_BOUNDS_CHECK_EN
//   defined   - off-screen plots are accepted but discarded; dropped is sticky
//   undefined - no check, address wraps; dropped tied low
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   plot, x, y, colour       pixel stream in, accepted when plot && plot_ready
//   plot_ready               buffer can take a plot this cycle
//   clear_req, clear_colour  single-cycle full-screen fill request
//   fb_grant                 framebuffer write port available this cycle
//   fb_we, fb_addr, fb_data  framebuffer write port (addr/data hold when idle)
//   busy                     work pending
//   dropped                  sticky off-screen discard flag
// -----------------------------------------------------------------------------
module pixel_write_buffer
    import pixel_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 plot,
    input  logic [7:0]           x,
    input  logic [6:0]           y,
    input  logic [COL_W-1:0]     colour,
    output logic                 plot_ready,
    input  logic                 clear_req,
    input  logic [COL_W-1:0]     clear_colour,
    input  logic                 fb_grant,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [COL_W-1:0]     fb_data,
    output logic                 busy,
    output logic                 dropped
);

    localparam int EW = FB_ADDR_W + COL_W;

    state_t               state_q, state_d;
    logic                 clear_pending_q, clear_pending_d;
    logic [COL_W-1:0]     clr_col_q, clr_col_d;
    logic [FB_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [FB_ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [COL_W-1:0]     last_data_q, last_data_d;

    logic                 full, empty;
    logic [EW-1:0]        head;
    logic                 accept, in_range, push, pop;
    logic [FB_ADDR_W-1:0] cur_addr;
    logic [COL_W-1:0]     cur_data;

    pixel_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({pix_addr(x, y), colour}),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    // Input handshake
    always_comb begin
        plot_ready = !full && !clear_pending_q && (state_q != S_CLEAR);
        accept     = plot && plot_ready;
`ifdef PIXEL_WB_BOUNDS_CHECK_EN
        in_range   = (x < 8'(SCREEN_W)) && (y < 7'(SCREEN_H));
`else
        in_range   = 1'b1;
`endif
        push       = accept && in_range;
    end

    // Write port: clear counter during a fill, FIFO head otherwise.
    always_comb begin
        if (state_q == S_CLEAR) begin
            fb_we    = fb_grant;
            cur_addr = clr_cnt_q;
            cur_data = clr_col_q;
        end else begin
            fb_we    = fb_grant && !empty;
            cur_addr = head[EW-1:COL_W];
            cur_data = head[COL_W-1:0];
        end
        pop     = fb_we && (state_q != S_CLEAR);
        fb_addr = fb_we ? cur_addr : last_addr_q;
        fb_data = fb_we ? cur_data : last_data_q;
        busy    = (state_q != S_IDLE) || !empty || clear_pending_q;
    end

    // Next state and datapath registers
    always_comb begin
        state_d         = state_q;
        clear_pending_d = clear_pending_q;
        clr_col_d       = clr_col_q;
        clr_cnt_d       = clr_cnt_q;
        last_addr_d     = last_addr_q;
        last_data_d     = last_data_q;

        case (state_q)
            S_IDLE: begin
                if (!empty)              state_d = S_DRAIN;
                else if (clear_pending_q) state_d = S_CLEAR;
            end
            S_DRAIN: begin
                if (empty && clear_pending_q) state_d = S_CLEAR;
                else if (empty)               state_d = S_IDLE;
            end
            S_CLEAR: begin
                if (fb_grant && (clr_cnt_q == FB_LAST_ADDR)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A request is only taken outside a fill and when none is queued,
        // so a pending fill can never be restarted or recoloured.
        if ((state_q != S_CLEAR) && (state_d == S_CLEAR)) begin
            clear_pending_d = 1'b0;
        end else if (clear_req && (state_q != S_CLEAR) && !clear_pending_q) begin
            clear_pending_d = 1'b1;
            clr_col_d       = clear_colour;
        end

        if ((state_q == S_CLEAR) && fb_grant) begin
            clr_cnt_d = (clr_cnt_q == FB_LAST_ADDR) ? '0 : clr_cnt_q + FB_ADDR_W'(1);
        end

        if (fb_we) begin
            last_addr_d = cur_addr;
            last_data_d = cur_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            clear_pending_q <= 1'b0;
            clr_col_q       <= '0;
            clr_cnt_q       <= '0;
            last_addr_q     <= '0;
            last_data_q     <= '0;
        end else begin
            state_q         <= state_d;
            clear_pending_q <= clear_pending_d;
            clr_col_q       <= clr_col_d;
            clr_cnt_q       <= clr_cnt_d;
            last_addr_q     <= last_addr_d;
            last_data_q     <= last_data_d;
        end
    end

`ifdef PIXEL_WB_BOUNDS_CHECK_EN
    logic dropped_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dropped_q <= 1'b0;
        end else if (accept && !in_range) begin
            dropped_q <= 1'b1;
        end
    end

    assign dropped = dropped_q;
`else
    assign dropped = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_pixel_write_buffer
// Directed testbench for pixel_write_buffer. Inputs change on the falling
// edge; outputs are sampled 1 ns later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_pixel_write_buffer;
    import pixel_wb_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 plot;
    logic [7:0]           x;
    logic [6:0]           y;
    logic [COL_W-1:0]     colour;
    logic                 plot_ready;
    logic                 clear_req;
    logic [COL_W-1:0]     clear_colour;
    logic                 fb_grant;
    logic                 fb_we;
    logic [FB_ADDR_W-1:0] fb_addr;
    logic [COL_W-1:0]     fb_data;
    logic                 busy;
    logic                 dropped;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    pixel_write_buffer #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .plot         (plot),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot_ready   (plot_ready),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .fb_grant     (fb_grant),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .busy         (busy),
        .dropped      (dropped)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_plot(input int px, input int py, input int pc);
        plot   = 1'b1;
        x      = 8'(px);
        y      = 7'(py);
        colour = COL_W'(pc);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            #1;
            n++;
        end
        chk(tag, 32'(busy), 0);
    endtask

    // Runs a fill to completion, checking every write lands on the next
    // address with the expected colour and that no plot is accepted meanwhile.
    task automatic run_clear(input string tag, input bit toggle, input int col,
                             input bit inject);
        int  exp_addr;
        int  errs;
        int  rdy_errs;
        int  cyc;
        bit  pulsed;
        exp_addr = 0;
        errs     = 0;
        rdy_errs = 0;
        cyc      = 0;
        pulsed   = 1'b0;
        while (exp_addr < 19200 && cyc < 50000) begin
            tick();
            fb_grant = toggle ? cyc[0] : 1'b1;
            if (inject && !pulsed && exp_addr >= 100) begin
                clear_req    = 1'b1;
                clear_colour = 3'd4;
                pulsed       = 1'b1;
            end else begin
                clear_req = 1'b0;
            end
            #1;
            if (plot_ready) rdy_errs++;
            if (fb_we && !fb_grant) errs++;
            if (fb_we) begin
                if (32'(fb_addr) != exp_addr || 32'(fb_data) != col) errs++;
                exp_addr++;
            end
            cyc++;
        end
        clear_req = 1'b0;
        chk({tag, "_count"}, exp_addr, 19200);
        chk({tag, "_errs"}, errs, 0);
        chk({tag, "_ready"}, rdy_errs, 0);
    endtask

    initial begin
        int cnt;
        int n;

        reset        = 1'b1;
        plot         = 1'b0;
        x            = '0;
        y            = '0;
        colour       = '0;
        clear_req    = 1'b0;
        clear_colour = '0;
        fb_grant     = 1'b0;

        // Reset state
        tick();
        #1;
        chk("rst_we",    32'(fb_we), 0);
        chk("rst_addr",  32'(fb_addr), 0);
        chk("rst_data",  32'(fb_data), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_ready", 32'(plot_ready), 1);
        chk("rst_drop",  32'(dropped), 0);
        tick();
        reset = 1'b0;

        // Single plot, earliest write latency
        tick();
        fb_grant = 1'b1;
        set_plot(5, 2, 3);
        #1;
        chk("t1_ready", 32'(plot_ready), 1);
        chk("t1_we_early", 32'(fb_we), 0);
        tick();
        plot = 1'b0;
        #1;
        chk("t1_we",   32'(fb_we), 1);
        chk("t1_addr", 32'(fb_addr), 325);
        chk("t1_data", 32'(fb_data), 3);
        chk("t1_busy", 32'(busy), 1);
        tick();
        #1;
        chk("t1_we_after", 32'(fb_we), 0);
        chk("t1_hold_addr", 32'(fb_addr), 325);
        chk("t1_hold_data", 32'(fb_data), 3);
        wait_idle("t1_idle", 10);

        // Streaming: push and pop in the same cycle
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k < 3) set_plot(k, 0, k + 4);
            else       plot = 1'b0;
            #1;
            chk("t2_ready", 32'(plot_ready), 1);
            if (k == 0) begin
                chk("t2_we0", 32'(fb_we), 0);
            end else begin
                chk("t2_we",   32'(fb_we), 1);
                chk("t2_addr", 32'(fb_addr), k - 1);
                chk("t2_data", 32'(fb_data), k + 3);
            end
        end
        wait_idle("t2_idle", 10);

        // Fill the FIFO with the port stalled
        fb_grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            set_plot(10 + i, i, i + 1);
            #1;
            chk("t3_ready", 32'(plot_ready), 32'(i < 4));
            chk("t3_we_stall", 32'(fb_we), 0);
        end
        tick();
        plot = 1'b0;
        #1;
        chk("t3_busy", 32'(busy), 1);
        chk("t3_ready_full", 32'(plot_ready), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            fb_grant = 1'b1;
            #1;
            chk("t3_we",   32'(fb_we), 1);
            chk("t3_addr", 32'(fb_addr), 161 * i + 10);
            chk("t3_data", 32'(fb_data), i + 1);
        end
        tick();
        #1;
        chk("t3_we_end", 32'(fb_we), 0);
        chk("t3_ready_end", 32'(plot_ready), 1);
        wait_idle("t3_idle", 10);

        // Screen corner and the first off-screen column
        tick();
        set_plot(159, 119, 7);
        tick();
        set_plot(160, 0, 5);
        #1;
        chk("t4_ready", 32'(plot_ready), 1);
        chk("t4_we",    32'(fb_we), 1);
        chk("t4_addr",  32'(fb_addr), 19199);
        chk("t4_data",  32'(fb_data), 7);
        tick();
        plot = 1'b0;
        #1;
`ifdef PIXEL_WB_BOUNDS_CHECK_EN
        chk("t4_oob_we", 32'(fb_we), 0);
        chk("t4_drop",   32'(dropped), 1);
`else
        chk("t4_oob_we",   32'(fb_we), 1);
        chk("t4_oob_addr", 32'(fb_addr), 160);
        chk("t4_oob_data", 32'(fb_data), 5);
        chk("t4_drop",     32'(dropped), 0);
`endif
        wait_idle("t4_idle", 10);

        // Clear behind two queued plots
        fb_grant = 1'b0;
        tick();
        set_plot(1, 1, 2);
        tick();
        set_plot(2, 3, 6);
        tick();
        plot         = 1'b0;
        clear_req    = 1'b1;
        clear_colour = 3'd1;
        tick();
        clear_req = 1'b0;
        #1;
        chk("t5_ready_pend", 32'(plot_ready), 0);
        chk("t5_busy_pend",  32'(busy), 1);
        chk("t5_we_stall",   32'(fb_we), 0);
        tick();
        fb_grant = 1'b1;
        #1;
        chk("t5_p0_addr", 32'(fb_addr), 161);
        chk("t5_p0_data", 32'(fb_data), 2);
        tick();
        #1;
        chk("t5_p1_addr", 32'(fb_addr), 482);
        chk("t5_p1_data", 32'(fb_data), 6);
        run_clear("t5_clear", 1'b0, 1, 1'b0);
        tick();
        #1;
        chk("t5_busy_done",  32'(busy), 0);
        chk("t5_ready_done", 32'(plot_ready), 1);
        chk("t5_hold_addr",  32'(fb_addr), 19199);

        // Clear with a stuttering grant and an ignored second request
        tick();
        fb_grant     = 1'b0;
        clear_req    = 1'b1;
        clear_colour = 3'd1;
        tick();
        clear_req = 1'b0;
        run_clear("t6_clear", 1'b1, 1, 1'b1);
        fb_grant = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            if (fb_we || busy) cnt++;
        end
        chk("t6_no_restart", cnt, 0);

        // Reset in the middle of a clear
        tick();
        clear_req    = 1'b1;
        clear_colour = 3'd1;
        tick();
        clear_req = 1'b0;
        cnt = 0;
        n   = 0;
        while (cnt < 5000 && n < 10000) begin
            tick();
            #1;
            if (fb_we) cnt++;
            n++;
        end
        chk("t7_reached", cnt, 5000);
        tick();
        reset = 1'b1;
        #1;
        chk("t7_rst_we",    32'(fb_we), 0);
        chk("t7_rst_busy",  32'(busy), 0);
        chk("t7_rst_ready", 32'(plot_ready), 1);
        chk("t7_rst_addr",  32'(fb_addr), 0);
        tick();
        reset = 1'b0;
        tick();
        set_plot(0, 0, 2);
        #1;
        chk("t7_we_early", 32'(fb_we), 0);
        tick();
        plot = 1'b0;
        #1;
        chk("t7_we",   32'(fb_we), 1);
        chk("t7_addr", 32'(fb_addr), 0);
        chk("t7_data", 32'(fb_data), 2);
        wait_idle("t7_idle", 10);

        // A fresh clear after reset starts from address 0
        tick();
        clear_req    = 1'b1;
        clear_colour = 3'd5;
        tick();
        clear_req = 1'b0;
        n = 0;
        while (!fb_we && n < 10) begin
            tick();
            #1;
            n++;
        end
        chk("t8_we",   32'(fb_we), 1);
        chk("t8_addr", 32'(fb_addr), 0);
        chk("t8_data", 32'(fb_data), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
